// File: rtl/wb_port_arbiter_if.sv
// Bus bundle for the register-file write-port arbiter: WriteBack request,
// long-latency result handshake, register-file write port and status outputs.
interface wb_port_arbiter_if #(
    parameter int M     = 32,
    parameter int N     = 5,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic              regWriteW;
    logic [N-1:0]      writeRW;
    logic [M-1:0]      resultW;
    logic              llValid;
    logic [N-1:0]      llDest;
    logic [M-1:0]      llData;
    logic              llReady;
    logic              rfWE;
    logic [N-1:0]      rfWA;
    logic [M-1:0]      rfWD;
    logic              stallReq;
    logic [(1<<N)-1:0] pendMask;
    logic [CW-1:0]     count;

    modport slave (
        input  regWriteW, writeRW, resultW, llValid, llDest, llData,
        output llReady, rfWE, rfWA, rfWD, stallReq, pendMask, count
    );

    modport master (
        output regWriteW, writeRW, resultW, llValid, llDest, llData,
        input  llReady, rfWE, rfWA, rfWD, stallReq, pendMask, count
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between WriteBack (priority) and an
// in-order FIFO of long-latency results; requests a stall when the head starves.
module wb_port_arbiter #(
    parameter int M      = 32,
    parameter int N      = 5,
    parameter int DEPTH  = 2,
    parameter int STARVE = 4
) (
    input  logic              CLK,
    input  logic              RSTn,
    wb_port_arbiter_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WW = $clog2(STARVE + 1);
    localparam int RN = 1 << N;

    logic [N-1:0]     dest_r [DEPTH];
    logic [M-1:0]     data_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic [WW-1:0]    wait_r;
    logic             stall_r;

    logic             wb_eff_s;
    logic             ready_s;
    logic             push_s;
    logic             pop_s;
    logic             rfwe_s;
    logic [N-1:0]     rfwa_s;
    logic [M-1:0]     rfwd_s;
    logic [CW-1:0]    count_nxt_s;
    logic [WW-1:0]    wait_nxt_s;
    logic [RN-1:0]    pend_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    // Grant: WriteBack wins, otherwise the FIFO head uses the idle slot.
    // Everything is gated by RSTn so the port is silent while reset is held.
    always_comb begin
        wb_eff_s = bus.regWriteW && (bus.writeRW != {N{1'b0}});
        ready_s  = RSTn && (count_r < CW'(DEPTH));
        push_s   = bus.llValid && ready_s && (bus.llDest != {N{1'b0}});
        pop_s    = RSTn && !wb_eff_s && (count_r != {CW{1'b0}});
        rfwe_s   = 1'b0;
        rfwa_s   = {N{1'b0}};
        rfwd_s   = {M{1'b0}};
        if (!RSTn) begin
            rfwe_s = 1'b0;
        end else if (wb_eff_s) begin
            rfwe_s = 1'b1;
            rfwa_s = bus.writeRW;
            rfwd_s = bus.resultW;
        end else if (count_r != {CW{1'b0}}) begin
            rfwe_s = 1'b1;
            rfwa_s = dest_r[rd_ptr_r];
            rfwd_s = data_r[rd_ptr_r];
        end else begin
            rfwe_s = 1'b0;
        end
    end

    // Next occupancy and head wait counter (saturating, cleared on pop or empty).
    always_comb begin
        count_nxt_s = count_r;
        wait_nxt_s  = wait_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CW'(1);
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CW'(1);
        end else begin
            count_nxt_s = count_r;
        end
        if (pop_s || (count_r == {CW{1'b0}})) begin
            wait_nxt_s = {WW{1'b0}};
        end else if (wait_r < WW'(STARVE)) begin
            wait_nxt_s = wait_r + WW'(1);
        end else begin
            wait_nxt_s = wait_r;
        end
    end

    // Pending-destination mask: OR of one-hot destinations over valid slots.
    always_comb begin
        pend_s = {RN{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            pend_s = pend_s | (valid_r[i] ? ({{(RN-1){1'b0}}, 1'b1} << dest_r[i]) : {RN{1'b0}});
        end
    end

    // FIFO storage, pointers and occupancy; push and pop never hit the same slot.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < DEPTH; i++) begin
                dest_r[i] <= {N{1'b0}};
                data_r[i] <= {M{1'b0}};
            end
            valid_r  <= {DEPTH{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (pop_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= ptr_inc(rd_ptr_r);
            end
            if (push_s) begin
                dest_r[wr_ptr_r]  <= bus.llDest;
                data_r[wr_ptr_r]  <= bus.llData;
                valid_r[wr_ptr_r] <= 1'b1;
                wr_ptr_r          <= ptr_inc(wr_ptr_r);
            end
            count_r <= count_nxt_s;
        end
    end

    // Starvation tracking; the stall flag mirrors a saturated wait counter.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wait_r  <= {WW{1'b0}};
            stall_r <= 1'b0;
        end else begin
            wait_r  <= wait_nxt_s;
            stall_r <= (wait_nxt_s == WW'(STARVE));
        end
    end

    assign bus.llReady  = ready_s;
    assign bus.rfWE     = rfwe_s;
    assign bus.rfWA     = rfwa_s;
    assign bus.rfWD     = rfwd_s;
    assign bus.stallReq = stall_r;
    assign bus.pendMask = pend_s;
    assign bus.count    = count_r;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_wb_port_arbiter;
    localparam int M = 32, N = 5, DEPTH = 2, STARVE = 4;

    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    int   checks = 0;
    int   failures = 0;

    wb_port_arbiter_if #(.M(M), .N(N), .DEPTH(DEPTH)) bus ();
    wb_port_arbiter #(.M(M), .N(N), .DEPTH(DEPTH), .STARVE(STARVE)) dut (
        .CLK(CLK), .RSTn(RSTn), .bus(bus.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [N-1:0] d; logic [M-1:0] v; } ent_t;
    ent_t mq[$];
    int   age = 0;

    typedef struct {
        logic rw; logic [4:0] wa; logic [31:0] wd;
        logic v;  logic [4:0] ld; logic [31:0] lv;
        logic e_we; logic [4:0] e_wa; logic [31:0] e_wd;
        logic e_rdy; logic [1:0] e_cnt; logic [31:0] e_pend;
    } vec_t;
    vec_t tbl[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic [4:0] wa, input logic [31:0] wd,
                         input logic v, input logic [4:0] ld, input logic [31:0] lv);
        bus.regWriteW = rw; bus.writeRW = wa; bus.resultW = wd;
        bus.llValid = v; bus.llDest = ld; bus.llData = lv;
    endtask

    // Compare all outputs against the reference model mid-cycle.
    task automatic settle();
        logic eff;
        logic [31:0] p;
        @(negedge CLK);
        eff = bus.regWriteW && (bus.writeRW != 5'd0);
        p = 32'd0;
        foreach (mq[i]) p[mq[i].d] = 1'b1;
        chk("m_rfWE", {63'd0, bus.rfWE}, {63'd0, eff || (mq.size() > 0)});
        chk("m_rfWA", {59'd0, bus.rfWA},
            {59'd0, eff ? bus.writeRW : (mq.size() > 0 ? mq[0].d : 5'd0)});
        chk("m_rfWD", {32'd0, bus.rfWD},
            {32'd0, eff ? bus.resultW : (mq.size() > 0 ? mq[0].v : 32'd0)});
        chk("m_llReady", {63'd0, bus.llReady}, {63'd0, mq.size() < DEPTH});
        chk("m_count", {62'd0, bus.count}, 64'(mq.size()));
        chk("m_pendMask", {32'd0, bus.pendMask}, {32'd0, p});
        chk("m_stallReq", {63'd0, bus.stallReq}, {63'd0, age >= STARVE});
    endtask

    // Clock edge: update the reference model from the applied inputs.
    task automatic advance();
        logic eff, rdy, was_empty, popped;
        @(posedge CLK);
        eff = bus.regWriteW && (bus.writeRW != 5'd0);
        rdy = mq.size() < DEPTH;
        was_empty = (mq.size() == 0);
        popped = 1'b0;
        if (!eff && mq.size() > 0) begin
            void'(mq.pop_front());
            popped = 1'b1;
        end
        if (bus.llValid && rdy && bus.llDest != 5'd0) mq.push_back('{bus.llDest, bus.llData});
        if (popped || was_empty) age = 0; else age++;
        #1;
    endtask

    initial begin
        drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd3, 32'h33);
        // Reset held with active requests
        @(negedge CLK); @(negedge CLK);
        chk("rst_rfWE", {63'd0, bus.rfWE}, 64'd0);
        chk("rst_llReady", {63'd0, bus.llReady}, 64'd0);
        chk("rst_count", {62'd0, bus.count}, 64'd0);
        chk("rst_rfWA", {59'd0, bus.rfWA}, 64'd0);
        chk("rst_pend", {32'd0, bus.pendMask}, 64'd0);
        chk("rst_stall", {63'd0, bus.stallReq}, 64'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        RSTn = 1'b1;
        #1;
        chk("rel_llReady", {63'd0, bus.llReady}, 64'd1);
        advance();

        //            rw   wa     wd            v    ld     lv              we   wa     wd             rdy  cnt   pend
        tbl[0]  = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b1, 2'd0, 32'h0};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'hDEADBEEF, 1'b1, 2'd1, 32'h80};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 32'h33,       1'b0, 5'd0, 32'h0,        1'b1, 2'd0, 32'h0};
        tbl[3]  = '{1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'h11,       1'b1, 2'd1, 32'h8};
        tbl[4]  = '{1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'h11,       1'b1, 2'd1, 32'h8};
        tbl[5]  = '{1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'h11,       1'b1, 2'd1, 32'h8};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h33,       1'b1, 2'd1, 32'h8};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 32'h99,       1'b0, 5'd0, 32'h0,        1'b1, 2'd0, 32'h0};
        tbl[8]  = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 32'h909,      1'b0, 5'd0, 32'h0,        1'b1, 2'd0, 32'h0};
        tbl[9]  = '{1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h909,      1'b1, 2'd1, 32'h200};
        tbl[10] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 2'd0, 32'h0};
        tbl[11] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd2, 32'h22,       1'b0, 5'd0, 32'h0,        1'b1, 2'd0, 32'h0};
        tbl[12] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd6, 32'h66,       1'b1, 5'd2, 32'h22,       1'b1, 2'd1, 32'h4};
        tbl[13] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        1'b1, 5'd6, 32'h66,       1'b1, 2'd1, 32'h40};
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].rw, tbl[i].wa, tbl[i].wd, tbl[i].v, tbl[i].ld, tbl[i].lv);
            settle();
            chk($sformatf("v%0d_rfWE", i), {63'd0, bus.rfWE}, {63'd0, tbl[i].e_we});
            chk($sformatf("v%0d_rfWA", i), {59'd0, bus.rfWA}, {59'd0, tbl[i].e_wa});
            chk($sformatf("v%0d_rfWD", i), {32'd0, bus.rfWD}, {32'd0, tbl[i].e_wd});
            chk($sformatf("v%0d_llReady", i), {63'd0, bus.llReady}, {63'd0, tbl[i].e_rdy});
            chk($sformatf("v%0d_count", i), {62'd0, bus.count}, {62'd0, tbl[i].e_cnt});
            chk($sformatf("v%0d_pend", i), {32'd0, bus.pendMask}, {32'd0, tbl[i].e_pend});
            advance();
        end

        // Full FIFO with duplicate destination under continuous WB writes
        drive(1'b1, 5'd1, 32'hA1, 1'b1, 5'd4, 32'h41); settle(); advance();
        drive(1'b1, 5'd1, 32'hA1, 1'b1, 5'd4, 32'h42); settle(); advance();
        drive(1'b1, 5'd1, 32'hA1, 1'b1, 5'd4, 32'h43); settle();
        chk("full_llReady", {63'd0, bus.llReady}, 64'd0);
        chk("full_pend4", {63'd0, bus.pendMask[4]}, 64'd1);
        advance();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h43); settle();
        chk("full_drain1_wd", {32'd0, bus.rfWD}, 64'h41);
        advance();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0); settle();
        chk("drain1_pend4", {63'd0, bus.pendMask[4]}, 64'd1);
        chk("drain2_wd", {32'd0, bus.rfWD}, 64'h42);
        advance();
        settle();
        chk("drain2_pend4", {63'd0, bus.pendMask[4]}, 64'd0);
        advance();

        // Starvation: one queued entry held off by WB writes
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h88); settle(); advance();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'd10, 32'hB0, 1'b0, 5'd0, 32'h0); settle();
            chk($sformatf("starve_pre%0d", k), {63'd0, bus.stallReq}, 64'd0);
            advance();
        end
        settle();
        chk("starve_set", {63'd0, bus.stallReq}, 64'd1);
        advance();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0); settle();
        chk("starve_hold", {63'd0, bus.stallReq}, 64'd1);
        chk("starve_drain_wa", {59'd0, bus.rfWA}, 64'd8);
        advance();
        settle();
        chk("starve_clear", {63'd0, bus.stallReq}, 64'd0);
        advance();

        // Reset mid-operation discards the queued entry
        drive(1'b1, 5'd2, 32'h12, 1'b1, 5'd11, 32'hBB); settle(); advance();
        drive(1'b1, 5'd2, 32'h12, 1'b0, 5'd0, 32'h0);
        RSTn = 1'b0;
        #1;
        chk("mid_rst_count", {62'd0, bus.count}, 64'd0);
        chk("mid_rst_pend", {32'd0, bus.pendMask}, 64'd0);
        mq.delete();
        age = 0;
        @(negedge CLK);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        RSTn = 1'b1;
        advance();
        settle();
        chk("mid_rst_nowrite", {63'd0, bus.rfWE}, 64'd0);
        advance();

        // Random traffic, alternating light and heavy WriteBack load
        for (int c = 0; c < 600; c++) begin
            int thr;
            thr = ((c / 40) % 2 == 0) ? 40 : 92;
            drive($urandom_range(0, 99) < thr,
                  ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  $urandom(),
                  $urandom_range(0, 99) < 50,
                  5'($urandom_range(0, 7)),
                  $urandom());
            settle();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
